// File: rtl/aes_rcon_inv_if.sv
// ============================================================================
// Module      : aes_rcon_inv_if
// Description : Control/result bundle between the key-schedule controller and
//               the reverse round-constant sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_rcon_inv_if;
    logic       init;
    logic       keylen;
    logic       next;
    logic [7:0] rcon;
    logic [3:0] round;
    logic       ready;
    logic       last;
    logic       done;
    logic       err;

    modport master (
        output init, keylen, next,
        input  rcon, round, ready, last, done, err
    );

    modport slave (
        input  init, keylen, next,
        output rcon, round, ready, last, done, err
    );
endinterface

`default_nettype wire

// File: rtl/aes_rcon_inv.sv
// ============================================================================
// Module      : aes_rcon_inv
// Description : Reverse-direction AES round-constant sequencer. Seeks forward
//               to the final rcon for the key length, then steps backwards.
//               Optional self-check enabled by macro AES_RCON_INV_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_rcon_inv #(
    parameter int unsigned ROUNDS_128 = 10,
    parameter int unsigned ROUNDS_256 = 7
) (
    input  wire               clk,
    input  wire               reset_n,
    aes_rcon_inv_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEEK  = 2'd1,
        S_READY = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] rcon_q,  rcon_d;
    logic [3:0] round_q, round_d;
    logic [3:0] target_q, target_d;

    function automatic logic [7:0] rcon_fwd(input logic [7:0] r);
        logic [8:0] t;
        t = {r, 1'b0} ^ (9'h11b & {9{r[7]}});
        return t[7:0];
    endfunction

    function automatic logic [7:0] rcon_inv(input logic [7:0] r);
        return (r >> 1) ^ (8'h8d & {8{r[0]}});
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rcon_q   <= 8'h00;
            round_q  <= 4'd0;
            target_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            rcon_q   <= rcon_d;
            round_q  <= round_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rcon_d   = rcon_q;
        round_d  = round_q;
        target_d = target_q;
        if (bus.init) begin
            state_d  = S_SEEK;
            rcon_d   = 8'h01;
            round_d  = 4'd1;
            target_d = bus.keylen ? 4'(ROUNDS_256) : 4'(ROUNDS_128);
        end else begin
            case (state_q)
                S_SEEK: begin
                    if (round_q != target_q) begin
                        rcon_d  = rcon_fwd(rcon_q);
                        round_d = round_q + 4'd1;
                    end else begin
                        state_d = S_READY;
                    end
                end
                S_READY: begin
                    if (bus.next) begin
                        rcon_d  = rcon_inv(rcon_q);
                        round_d = round_q - 4'd1;
                        // Stepping past round 1 lands on inv(0x01) = 0x8d.
                        if (round_q == 4'd1) begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rcon  = rcon_q;
    assign bus.round = round_q;
    assign bus.ready = (state_q == S_READY);
    assign bus.done  = (state_q == S_DONE);
    assign bus.last  = (state_q == S_READY) && (round_q == 4'd1);

`ifdef AES_RCON_INV_CHECK_EN
    logic err_q, err_d;

    function automatic logic [7:0] rcon_ref(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h8d;
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        err_d = err_q;
        if (bus.init) begin
            err_d = 1'b0;
        end else if (((state_q == S_READY) || (state_q == S_DONE)) &&
                     (rcon_q != rcon_ref(round_q))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_rcon_inv.sv
// ============================================================================
// Module      : tb_aes_rcon_inv
// Description : Directed self-checking bench for aes_rcon_inv. The err
//               injection scenario is built when AES_RCON_INV_CHECK_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_rcon_inv;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    aes_rcon_inv_if bus ();

    aes_rcon_inv #(
        .ROUNDS_128 (10),
        .ROUNDS_256 (7)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        bus.init   = 1'b0;
        bus.keylen = 1'b0;
        bus.next   = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.rcon !== 8'h00) begin
            errors++; $display("FAIL reset_rcon got %h expected 00", bus.rcon);
        end
        checks++;
        if (bus.round !== 4'd0) begin
            errors++; $display("FAIL reset_round got %0d expected 0", bus.round);
        end
        checks++;
        if ({bus.ready, bus.done, bus.last, bus.err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got rdy/done/last/err=%b expected 0000",
                     {bus.ready, bus.done, bus.last, bus.err});
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_aes128_seek();
        bus.keylen = 1'b0;
        bus.init   = 1'b1;
        tick();
        bus.init   = 1'b0;
        checks++;
        if (bus.rcon !== 8'h01 || bus.round !== 4'd1 || bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL seek128_start got rcon=%h round=%0d ready=%b expected 01/1/0",
                     bus.rcon, bus.round, bus.ready);
        end
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if (bus.ready !== 1'b0) begin
                errors++; $display("FAIL seek128_early_ready edge %0d got %b expected 0", i, bus.ready);
            end
        end
        tick();
        checks++;
        if (bus.ready !== 1'b1 || bus.rcon !== 8'h36 || bus.round !== 4'd10 || bus.last !== 1'b0) begin
            errors++;
            $display("FAIL seek128_ready got ready=%b rcon=%h round=%0d last=%b expected 1/36/10/0",
                     bus.ready, bus.rcon, bus.round, bus.last);
        end
    endtask

    task automatic test_aes128_walk();
        logic [7:0] exp_rcon [9];
        exp_rcon = '{8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        for (int i = 0; i < 9; i++) begin
            bus.next = 1'b1;
            tick();
            bus.next = 1'b0;
            checks++;
            if (bus.rcon !== exp_rcon[i] || bus.round !== 4'(9 - i) || bus.ready !== 1'b1 ||
                bus.last !== (i == 8) || bus.err !== 1'b0) begin
                errors++;
                $display("FAIL walk128 step %0d got rcon=%h round=%0d ready=%b last=%b err=%b expected %h/%0d/1/%b/0",
                         i, bus.rcon, bus.round, bus.ready, bus.last, bus.err, exp_rcon[i], 9 - i, (i == 8));
            end
            tick();
            checks++;
            if (bus.rcon !== exp_rcon[i] || bus.round !== 4'(9 - i)) begin
                errors++;
                $display("FAIL walk128_hold step %0d got rcon=%h round=%0d expected %h/%0d",
                         i, bus.rcon, bus.round, exp_rcon[i], 9 - i);
            end
        end
        for (int i = 0; i < 3; i++) begin
            bus.next = 1'b1;
            tick();
            bus.next = 1'b0;
            checks++;
            if (bus.done !== 1'b1 || bus.ready !== 1'b0 || bus.rcon !== 8'h8d ||
                bus.round !== 4'd0 || bus.last !== 1'b0 || bus.err !== 1'b0) begin
                errors++;
                $display("FAIL walk128_done pulse %0d got done=%b ready=%b rcon=%h round=%0d last=%b err=%b expected 1/0/8d/0/0/0",
                         i, bus.done, bus.ready, bus.rcon, bus.round, bus.last, bus.err);
            end
        end
    endtask

    // next is held from the init edge onward: ignored while seeking, then
    // steps once per cycle in READY.
    task automatic test_aes256_continuous();
        logic [7:0] exp_rcon [6];
        exp_rcon = '{8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        bus.keylen = 1'b1;
        bus.init   = 1'b1;
        tick();
        bus.init   = 1'b0;
        bus.keylen = 1'b0;
        bus.next   = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (bus.ready !== 1'b0 || bus.round !== 4'(i + 1)) begin
                errors++;
                $display("FAIL seek256 edge %0d got ready=%b round=%0d expected 0/%0d",
                         i, bus.ready, bus.round, i + 1);
            end
        end
        tick();
        checks++;
        if (bus.ready !== 1'b1 || bus.rcon !== 8'h40 || bus.round !== 4'd7) begin
            errors++;
            $display("FAIL seek256_ready got ready=%b rcon=%h round=%0d expected 1/40/7",
                     bus.ready, bus.rcon, bus.round);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (bus.rcon !== exp_rcon[i] || bus.round !== 4'(6 - i) || bus.last !== (i == 5)) begin
                errors++;
                $display("FAIL walk256 step %0d got rcon=%h round=%0d last=%b expected %h/%0d/%b",
                         i, bus.rcon, bus.round, bus.last, exp_rcon[i], 6 - i, (i == 5));
            end
        end
        tick();
        bus.next = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.rcon !== 8'h8d || bus.round !== 4'd0) begin
            errors++;
            $display("FAIL walk256_done got done=%b rcon=%h round=%0d expected 1/8d/0",
                     bus.done, bus.rcon, bus.round);
        end
    endtask

    task automatic test_hazards();
        bus.keylen = 1'b1;
        bus.init   = 1'b1;
        tick();
        bus.init   = 1'b0;
        repeat (7) tick();
        checks++;
        if (bus.ready !== 1'b1 || bus.rcon !== 8'h40) begin
            errors++;
            $display("FAIL hazard_setup got ready=%b rcon=%h expected 1/40", bus.ready, bus.rcon);
        end
        bus.init   = 1'b1;
        bus.keylen = 1'b0;
        bus.next   = 1'b1;
        tick();
        bus.init   = 1'b0;
        bus.next   = 1'b0;
        checks++;
        if (bus.rcon !== 8'h01 || bus.round !== 4'd1 || bus.ready !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL init_with_next got rcon=%h round=%0d ready=%b done=%b expected 01/1/0/0",
                     bus.rcon, bus.round, bus.ready, bus.done);
        end
        repeat (3) tick();
        checks++;
        if (bus.rcon !== 8'h08 || bus.round !== 4'd4) begin
            errors++;
            $display("FAIL seek_progress got rcon=%h round=%0d expected 08/4", bus.rcon, bus.round);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++;
        if (bus.rcon !== 8'h00 || bus.round !== 4'd0 ||
            {bus.ready, bus.done, bus.last, bus.err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_seek got rcon=%h round=%0d flags=%b expected 00/0/0000",
                     bus.rcon, bus.round, {bus.ready, bus.done, bus.last, bus.err});
        end
        repeat (12) tick();
        checks++;
        if (bus.round !== 4'd0 || bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got round=%0d ready=%b expected 0/0", bus.round, bus.ready);
        end
        bus.next = 1'b1;
        tick();
        bus.next = 1'b0;
        checks++;
        if (bus.rcon !== 8'h00 || bus.round !== 4'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL next_in_idle got rcon=%h round=%0d done=%b expected 00/0/0",
                     bus.rcon, bus.round, bus.done);
        end
    endtask

    task automatic test_err();
        bus.keylen = 1'b0;
        bus.init   = 1'b1;
        tick();
        bus.init   = 1'b0;
        repeat (10) tick();
        checks++;
        if (bus.ready !== 1'b1 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL err_clean got ready=%b err=%b expected 1/0", bus.ready, bus.err);
        end
`ifdef AES_RCON_INV_CHECK_EN
        force dut.rcon_q = 8'h37;
        tick();
        release dut.rcon_q;
        checks++;
        if (bus.err !== 1'b1) begin
            errors++; $display("FAIL err_detect got %b expected 1", bus.err);
        end
        tick();
        checks++;
        if (bus.err !== 1'b1) begin
            errors++; $display("FAIL err_sticky got %b expected 1", bus.err);
        end
        bus.init = 1'b1;
        tick();
        bus.init = 1'b0;
        checks++;
        if (bus.err !== 1'b0) begin
            errors++; $display("FAIL err_clear got %b expected 0", bus.err);
        end
`else
        bus.next = 1'b1;
        repeat (10) tick();
        bus.next = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL err_tied_low got done=%b err=%b expected 1/0", bus.done, bus.err);
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_aes128_seek();
        test_aes128_walk();
        test_aes256_continuous();
        test_hazards();
        test_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_rcon_inv.md
Name: aes_rcon_inv

Overview:
- Reverse-direction round-constant sequencer for the AES decryption key schedule.
- On `init`, seeks forward from rcon = 0x01 to the final round constant for the selected key length.
- Each `next` pulse then steps the constant backwards, one round at a time, down to round 1.
- Feeds the inverse key-expansion datapath, which consumes round keys last-to-first.

Parameters:
- ROUNDS_128, 10, number of rcon-using key-expansion rounds for AES-128 (seek target when keylen=0).
- ROUNDS_256, 7, number of rcon-using key-expansion rounds for AES-256 (seek target when keylen=1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- init  in  1  single-cycle pulse; starts a forward seek.
- keylen  in  1  0 = AES-128, 1 = AES-256; sampled only on the cycle init is high.
- next  in  1  single-cycle pulse; steps rcon one round backwards.
- rcon  out  8  current round constant (registered).
- round  out  4  current round index (registered).
- ready  out  1  high in READY state; rcon/round valid for consumption.
- last  out  1  high when ready and round == 1.
- done  out  1  high in DONE state.
- err  out  1  sticky self-check error; constant 0 unless AES_RCON_INV_CHECK_EN is defined.

Behaviour:
- Forward step: fwd(r) = ({r,1'b0} ^ (9'h11b & {9{r[7]}}))[7:0].
- Inverse step: inv(r) = (r >> 1) ^ (8'h8d & {8{r[0]}}).
- Reset (reset_n low at posedge): state IDLE, rcon 0x00, round 0, target 0, ready/last/done/err 0. Reset overrides init and next, including mid-SEEK.
- States: IDLE, SEEK, READY, DONE. ready = (state==READY); done = (state==DONE); last = ready & (round==1).
- Priority each cycle: reset > init > next.
- init, any state: rcon <= 0x01, round <= 1, target <= keylen ? ROUNDS_256 : ROUNDS_128, state <= SEEK, err cleared.
- SEEK:
  - If round != target: rcon <= fwd(rcon), round <= round+1.
  - Else: state <= READY, with no rcon change.
  - next is ignored.
  - Latency: ready rises at the 10th posedge after the init posedge for AES-128, and at the 7th for AES-256.
- READY, next high:
  - If round > 1: rcon <= inv(rcon), round <= round-1.
  - If round == 1: rcon <= inv(0x01) = 0x8d, round <= 0, state <= DONE.
- READY, next low: hold.
- DONE: next is ignored; outputs hold until init or reset.
- IDLE: next is ignored.
- next asserted for multiple cycles steps once per cycle; no edge detection.
- round is 4 bits, never wraps: it is bounded by target and 0.

Optional Feature:
- Macro: AES_RCON_INV_CHECK_EN.
- Defined:
  - Adds a 16-entry constant table: round 0 = 8d, then 01 02 04 08 10 20 40 80 1b 36; unused entries = 00.
  - Each cycle in READY or DONE, compare rcon against table[round].
  - On mismatch, set err to 1 on the next posedge. err is sticky until init or reset.
- Undefined: no table or comparator is built; err is tied to 0.

Test Plan:
1. Hold reset_n low 2 cycles -> rcon=0x00, round=0, ready=0, done=0, last=0, err=0.
2. init with keylen=0 -> ready=0 for 9 posedges, ready=1 at the 10th; rcon=0x36, round=10.
3. From (2), apply 9 single next pulses -> rcon sequence 1b,80,40,20,10,08,04,02,01, round decrements to 1 with last=1 at round 1. A 10th next -> done=1, ready=0, rcon=0x8d, round=0. Further next pulses change nothing.
4. init with keylen=1 -> ready at the 7th posedge with rcon=0x40, round=7. Continuous next for 7 cycles -> 20,10,08,04,02,01 then DONE with 0x8d.
5. Control hazards:
   - next held during SEEK -> no effect, same ready latency.
   - init and next together in READY -> restart (rcon=0x01, round=1, SEEK), next ignored.
   - reset_n low mid-SEEK -> IDLE, all outputs reset.
6. With AES_RCON_INV_CHECK_EN: run scenarios 2 and 3 -> err stays 0. Force rcon via a bench-only override to 0x37 at round 10 -> err=1 next cycle, cleared by init. Without the macro -> err=0 throughout.
